// File: rtl/multdiv_unit.sv
// multdiv_unit: multicycle signed multiply / divide for the execute stage.
// Multiply is radix-2 Booth, divide is restoring division on magnitudes with
// a sign fix-up at the end. Both take WIDTH iterations, so every operation
// completes WIDTH+1 cycles after its start edge. Results and exception are
// registered and only change when an operation completes.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam int            AW   = 2 * WIDTH + 2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;

    // Booth accumulator: {guard, high partial (WIDTH), multiplier (WIDTH), q-1}.
    // The guard bit keeps the most-negative multiplicand from overflowing the
    // high half when it is subtracted.
    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] mcand;

    // Restoring divider: quo starts as |dividend| and fills with quotient bits.
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             neg_q;
    logic             div_zero;
    logic             div_ovf;

    logic             start;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign start = ctrl_MULT | ctrl_DIV;
    assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // One Booth step: add/subtract the multiplicand per the low bit pair,
    // then shift the whole accumulator right arithmetically.
    logic [WIDTH:0]   booth_hi;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   mcand_ext;
    logic [AW-1:0]    acc_step;
    always_comb begin
        booth_hi  = acc[AW-1:WIDTH+1];
        mcand_ext = {mcand[WIDTH-1], mcand};
        booth_sum = booth_hi;
        case (acc[1:0])
            2'b01:   booth_sum = booth_hi + mcand_ext;
            2'b10:   booth_sum = booth_hi - mcand_ext;
            default: booth_sum = booth_hi;
        endcase
        acc_step = {booth_sum[WIDTH], booth_sum, acc[WIDTH:1]};
    end

    // One restoring-division step: shift in the next dividend bit, keep the
    // trial difference only when it did not go negative.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    always_comb begin
        rem_sh   = {rem, quo[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, dvsr};
        rem_step = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
        quo_step = {quo[WIDTH-2:0], ~rem_diff[WIDTH]};
    end

    // Final result formatting for both operations.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     prod_top;
    logic               mul_exc;
    logic [WIDTH-1:0]   div_res;
    always_comb begin
        prod     = acc[2*WIDTH:1];
        prod_top = prod[2*WIDTH-1:WIDTH-1];
        mul_exc  = !((&prod_top) | ~(|prod_top));
        div_res  = div_zero ? '0 : (neg_q ? -quo : quo);
    end

    // Control FSM plus datapath registers; a start in any state (re)launches.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            count          <= '0;
            acc            <= '0;
            mcand          <= '0;
            dvsr           <= '0;
            quo            <= '0;
            rem            <= '0;
            neg_q          <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start) begin
                state    <= ctrl_MULT ? MULT : DIV;
                count    <= '0;
                busy     <= 1'b1;
                mcand    <= data_operandA;
                acc      <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
                dvsr     <= mag_b;
                quo      <= mag_a;
                rem      <= '0;
                neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_zero <= (data_operandB == '0);
                div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
            end else begin
                case (state)
                    MULT: begin
                        if (count == LAST) begin
                            state          <= DONE;
                            busy           <= 1'b0;
                            data_resultRDY <= 1'b1;
                            data_result    <= prod[WIDTH-1:0];
                            data_exception <= mul_exc;
                        end else begin
                            acc   <= acc_step;
                            count <= count + CW'(1);
                        end
                    end
                    DIV: begin
                        if (count == LAST) begin
                            state          <= DONE;
                            busy           <= 1'b0;
                            data_resultRDY <= 1'b1;
                            data_result    <= div_res;
                            data_exception <= div_zero | div_ovf;
                        end else begin
                            rem   <= rem_step;
                            quo   <= quo_step;
                            count <= count + CW'(1);
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed corner cases plus random operations on a
// 32-bit and an 8-bit instance, checked against a plain-arithmetic model.
module tb_multdiv_unit;
    logic        clock;
    logic        reset;
    logic        m32, d32, m8, d8;
    logic [31:0] a32, b32, res32;
    logic [7:0]  a8, b8, res8;
    logic        exc32, rdy32, busy32, exc8, rdy8, busy8;

    int n_cmp = 0;
    int n_err = 0;

    multdiv_unit #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset), .ctrl_MULT(m32), .ctrl_DIV(d32),
        .data_operandA(a32), .data_operandB(b32), .data_result(res32),
        .data_exception(exc32), .data_resultRDY(rdy32), .busy(busy32));

    multdiv_unit #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .ctrl_MULT(m8), .ctrl_DIV(d8),
        .data_operandA(a8), .data_operandB(b8), .data_result(res8),
        .data_exception(exc8), .data_resultRDY(rdy8), .busy(busy8));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: signed arithmetic on sign-extended values, truncated to w bits.
    function automatic void model(input int w, input bit mul, input longint a, input longint b,
                                  output logic [63:0] r, output bit e);
        longint p, mn, mask;
        mask = (longint'(1) <<< w) - 1;
        mn   = -(longint'(1) <<< (w - 1));
        if (mul) begin
            p = a * b;
            e = (((p <<< (64 - w)) >>> (64 - w)) != p);
            r = p & mask;
        end else if (b == 0) begin
            r = 0; e = 1'b1;
        end else if (a == mn && b == -1) begin
            r = mn & mask; e = 1'b1;
        end else begin
            r = (a / b) & mask; e = 1'b0;
        end
    endfunction

    function automatic logic [63:0] res_of(input int w);
        return (w == 8) ? {56'b0, res8} : {32'b0, res32};
    endfunction
    function automatic logic rdy_of(input int w);
        return (w == 8) ? rdy8 : rdy32;
    endfunction
    function automatic logic busy_of(input int w);
        return (w == 8) ? busy8 : busy32;
    endfunction
    function automatic logic exc_of(input int w);
        return (w == 8) ? exc8 : exc32;
    endfunction

    // Launch one operation, then check busy, hold, latency, result and strobe.
    task automatic run_op(input int w, input bit m, input bit d,
                          input logic [31:0] a, input logic [31:0] b, input string tag);
        longint sa, sb;
        logic [63:0] er;
        bit ee, busy_ok, hold_ok;
        int cyc;
        logic [63:0] prev;
        sa = (w == 8) ? longint'($signed(a[7:0])) : longint'($signed(a));
        sb = (w == 8) ? longint'($signed(b[7:0])) : longint'($signed(b));
        model(w, m, sa, sb, er, ee);
        @(negedge clock);
        prev = res_of(w);
        if (w == 8) begin m8 = m; d8 = d; a8 = a[7:0]; b8 = b[7:0]; end
        else        begin m32 = m; d32 = d; a32 = a; b32 = b; end
        @(negedge clock);
        m8 = 0; d8 = 0; m32 = 0; d32 = 0;
        a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
        cyc = 0; busy_ok = 1; hold_ok = 1;
        while (!rdy_of(w) && cyc < w + 20) begin
            busy_ok &= busy_of(w);
            hold_ok &= (res_of(w) === prev);
            @(negedge clock);
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(w + 1));
        chk({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
        chk({tag, "_hold"}, 64'(hold_ok), 64'd1);
        chk({tag, "_busy_done"}, 64'(busy_of(w)), 64'd0);
        chk({tag, "_result"}, res_of(w), er);
        chk({tag, "_exc"}, 64'(exc_of(w)), 64'(ee));
        @(negedge clock);
        chk({tag, "_rdy_drop"}, 64'(rdy_of(w)), 64'd0);
    endtask

    initial begin
        int n_rdy, rdy_cyc;
        logic [63:0] got;
        bit nb;
        logic [31:0] ra, rb;
        reset = 1; m32 = 0; d32 = 0; m8 = 0; d8 = 0;
        a32 = 0; b32 = 0; a8 = 0; b8 = 0;
        #2 reset = 0;
        #1;
        chk("reset_result", {32'b0, res32}, 64'd0);
        chk("reset_exc", 64'(exc32), 64'd0);
        chk("reset_rdy", 64'(rdy32), 64'd0);
        chk("reset_busy", 64'(busy32), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1;

        // Directed multiplies and divides
        run_op(32, 1, 0, 32'd7, -32'sd6, "mul_7x-6");
        run_op(32, 1, 0, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
        run_op(32, 1, 0, 32'h7FFF_FFFF, 32'd1, "mul_max");
        run_op(32, 1, 0, 32'h8000_0000, 32'h8000_0000, "mul_minmin");
        run_op(8, 1, 0, 32'h7F, 32'h80, "mul8_127x-128");
        run_op(32, 0, 1, -32'sd100, 32'd7, "div_n100_7");
        run_op(32, 0, 1, 32'd100, -32'sd7, "div_100_n7");
        run_op(32, 0, 1, -32'sd100, -32'sd7, "div_n100_n7");
        run_op(32, 0, 1, 32'd6, 32'd7, "div_6_7");
        run_op(32, 0, 1, 32'd5, 32'd0, "div_by0");
        run_op(32, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(8, 0, 1, 32'h80, 32'hFF, "div8_ovf");
        run_op(32, 1, 1, 32'd9, 32'd3, "both_9x3");

        // Random operations on both widths
        for (int i = 0; i < 24; i++) begin
            nb = 1'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($signed(5'($urandom))) : $urandom;
            run_op(32, nb, !nb, ra, rb, nb ? "rnd_mul32" : "rnd_div32");
        end
        for (int i = 0; i < 10; i++) begin
            nb = 1'($urandom);
            run_op(8, nb, !nb, $urandom, $urandom_range(0, 255), nb ? "rnd_mul8" : "rnd_div8");
        end

        // Abort: multiply restarted by a divide ten cycles later
        @(negedge clock); m32 = 1; a32 = 3; b32 = 4;
        @(negedge clock); m32 = 0;
        repeat (9) @(negedge clock);
        d32 = 1; a32 = 20; b32 = 3;
        @(negedge clock); d32 = 0; a32 = 0; b32 = 0;
        n_rdy = 0; rdy_cyc = -1; got = '1;
        for (int c = 0; c < 60; c++) begin
            if (rdy32) begin
                n_rdy++;
                if (rdy_cyc < 0) begin rdy_cyc = c; got = {32'b0, res32}; end
            end
            @(negedge clock);
        end
        chk("abort_rdy_count", 64'(n_rdy), 64'd1);
        chk("abort_latency", 64'(rdy_cyc), 64'd33);
        chk("abort_result", got, 64'd6);

        // Reset in the middle of a multiply
        @(negedge clock); m32 = 1; a32 = 32'h1234_5678; b32 = 32'h0000_0345;
        @(negedge clock); m32 = 0;
        repeat (15) @(negedge clock);
        #2 reset = 0;
        #1;
        chk("midrst_busy", 64'(busy32), 64'd0);
        chk("midrst_rdy", 64'(rdy32), 64'd0);
        chk("midrst_result", {32'b0, res32}, 64'd0);
        chk("midrst_exc", 64'(exc32), 64'd0);
        @(negedge clock); reset = 1;
        n_rdy = 0;
        for (int c = 0; c < 40; c++) begin
            if (rdy32 || busy32) n_rdy++;
            @(negedge clock);
        end
        chk("postrst_quiet", 64'(n_rdy), 64'd0);
        run_op(32, 1, 0, 32'd2, 32'd3, "postrst_2x3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
